mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the FSM state encoding, the write size codes used on the we/mem_we
// buses, the port identifiers, and small helpers that decode a size code.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [2:0] SZ_NONE = 3'b000;
  localparam logic [2:0] SZ_B    = 3'b001;
  localparam logic [2:0] SZ_H    = 3'b011;
  localparam logic [2:0] SZ_W    = 3'b111;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  function automatic logic sizeCodeValid(input logic [2:0] we);
    return (we == SZ_NONE) || (we == SZ_B) || (we == SZ_H) || (we == SZ_W);
  endfunction

  // Bytes touched by an access; SZ_NONE means a read, which is always a word.
  function automatic logic [2:0] sizeBytes(input logic [2:0] we);
    case (we)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker.
// Ports:
//   i_req0, i_req1 : request lines of port 0 and port 1
//   i_prio         : port that wins when both request
//   o_grant        : some port is granted
//   o_port         : id of the granted port (0 when nobody requests)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_prio,
  output logic o_grant,
  output logic o_port
);

  assign o_grant = i_req0 | i_req1;

  // A lone requester wins outright; prio only breaks a tie.
  assign o_port = (i_req0 && i_req1) ? i_prio :
                  (i_req1 ? PORT_LSU : PORT_FETCH);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between a fetch port (0) and a
// load-store port (1). One command is served at a time through an
// IDLE -> ACCESS -> RESP sequence; illegal commands skip ACCESS and are
// answered with an error.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   req*/re*/we*/addr*/wdata*: per-port command, held until ack
//   ack*/err*/rdata          : one-cycle response of the served port
//   busy                     : arbiter not in IDLE
//   mem_*                    : memory interface, mem_rdata is combinational
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int MEMORY_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   re0,
  input  logic                   re1,
  input  logic [2:0]             we0,
  input  logic [2:0]             we1,
  input  logic [MEMORY_SIZE-1:0] addr0,
  input  logic [MEMORY_SIZE-1:0] addr1,
  input  logic [WORD_LENGTH-1:0] wdata0,
  input  logic [WORD_LENGTH-1:0] wdata1,
  output logic                   ack0,
  output logic                   ack1,
  output logic                   err0,
  output logic                   err1,
  output logic [WORD_LENGTH-1:0] rdata,
  output logic                   busy,
  output logic [MEMORY_SIZE-1:0] mem_addr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output logic [2:0]             mem_we,
  output logic                   mem_re,
  input  logic [WORD_LENGTH-1:0] mem_rdata
);

  logic [1:0]             r_state;
  logic                   r_prio;
  logic                   r_port;
  logic                   r_re;
  logic [2:0]             r_we;
  logic [MEMORY_SIZE-1:0] r_addr;
  logic [WORD_LENGTH-1:0] r_wdata;
  logic                   r_err;
  logic [WORD_LENGTH-1:0] r_rdata;

  logic                   w_grant;
  logic                   w_port;
  logic                   w_re;
  logic [2:0]             w_we;
  logic [MEMORY_SIZE-1:0] w_addr;
  logic [WORD_LENGTH-1:0] w_wdata;
  logic [MEMORY_SIZE:0]   w_end;
  logic                   w_illegal;
  logic                   w_inAccess;
  logic                   w_inResp;

  rr_arb2 u_rr_arb2 (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_prio  (r_prio),
    .o_grant (w_grant),
    .o_port  (w_port)
  );

  assign w_re    = w_port ? re1    : re0;
  assign w_we    = w_port ? we1    : we0;
  assign w_addr  = w_port ? addr1  : addr0;
  assign w_wdata = w_port ? wdata1 : wdata0;

  // One extra bit so an access near the top of the address space cannot
  // wrap around and look in range.
  assign w_end = {1'b0, w_addr} + {{(MEMORY_SIZE - 2){1'b0}}, sizeBytes(w_we)};

  assign w_illegal = !sizeCodeValid(w_we)
                  || ((w_we != SZ_NONE) && w_re)
                  || ((w_we == SZ_NONE) && !w_re)
                  || (w_end > (MEMORY_SIZE + 1)'(MEMORY_SIZE));

  // Command latch, round-robin priority and response capture. prio flips
  // to the other port whenever a response is entered, so a port that was
  // just served yields on the next tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_prio  <= PORT_FETCH;
      r_port  <= PORT_FETCH;
      r_re    <= 1'b0;
      r_we    <= SZ_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_port  <= w_port;
            r_re    <= w_re;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_err   <= w_illegal;
            if (w_illegal) begin
              r_state <= ST_RESP;
              r_prio  <= ~w_port;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          r_rdata <= r_re ? mem_rdata : '0;
          r_prio  <= ~r_port;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_inAccess = (r_state == ST_ACCESS);
  assign w_inResp   = (r_state == ST_RESP);

  assign busy = (r_state != ST_IDLE);

  // Strobes are gated by rst so a reset arriving mid-access never lets the
  // write commit at the edge that performs the reset.
  assign mem_addr  = w_inAccess ? r_addr  : '0;
  assign mem_wdata = w_inAccess ? r_wdata : '0;
  assign mem_we    = (w_inAccess && rst) ? r_we : SZ_NONE;
  assign mem_re    = w_inAccess && rst && r_re;

  assign ack0  = w_inResp && (r_port == PORT_FETCH);
  assign ack1  = w_inResp && (r_port == PORT_LSU);
  assign err0  = ack0 && r_err;
  assign err1  = ack1 && r_err;
  assign rdata = (w_inResp && !r_err && r_re) ? r_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a little-endian byte memory model.
// Expected responses are queued when a command is driven and compared when
// the arbiter acks it. Latency is counted in cycles, the cycle in which the
// command is first presented being cycle 1.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int WL = 32;
  localparam int MS = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, re0, re1;
  logic [2:0]    we0, we1;
  logic [MS-1:0] addr0, addr1;
  logic [WL-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1, busy;
  logic [WL-1:0] rdata;
  logic [MS-1:0] mem_addr;
  logic [WL-1:0] mem_wdata;
  logic [2:0]    mem_we;
  logic          mem_re;
  logic [WL-1:0] mem_rdata;

  typedef struct {
    logic          port;
    logic          err;
    logic [WL-1:0] rdata;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  logic memClear;
  logic [7:0] memModel [0:MS-1];

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_LENGTH(WL), .MEMORY_SIZE(MS)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .re0(re0), .re1(re1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  // Memory model: writes commit on the clock edge, reads are combinational.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < MS; i++) memModel[i] <= 8'h00;
    end else begin
      case (mem_we)
        SZ_B: memModel[mem_addr[4:0]] <= mem_wdata[7:0];
        SZ_H: begin
          memModel[mem_addr[4:0]]        <= mem_wdata[7:0];
          memModel[mem_addr[4:0] + 5'd1] <= mem_wdata[15:8];
        end
        SZ_W: begin
          memModel[mem_addr[4:0]]        <= mem_wdata[7:0];
          memModel[mem_addr[4:0] + 5'd1] <= mem_wdata[15:8];
          memModel[mem_addr[4:0] + 5'd2] <= mem_wdata[23:16];
          memModel[mem_addr[4:0] + 5'd3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    logic [4:0] a;
    a = mem_addr[4:0];
    mem_rdata = {memModel[a + 5'd3], memModel[a + 5'd2],
                 memModel[a + 5'd1], memModel[a]};
  end

  task automatic clearInputs();
    req0 = 1'b0; req1 = 1'b0; re0 = 1'b0; re1 = 1'b0;
    we0 = SZ_NONE; we1 = SZ_NONE; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  // One complete transaction on one port: drive, queue the expectation,
  // wait (bounded) for the ack, compare, then release the request.
  task automatic doTransaction(input string name, input logic port,
                               input logic re, input logic [2:0] we,
                               input logic [MS-1:0] addr,
                               input logic [WL-1:0] wdata,
                               input logic expErr,
                               input logic [WL-1:0] expRdata,
                               input int expLat);
    exp_t e;
    int   lat;
    logic seen;
    logic memTouched;
    @(posedge clk); #1;
    if (port == PORT_FETCH) begin
      req0 = 1'b1; re0 = re; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = 1'b1; re1 = re; we1 = we; addr1 = addr; wdata1 = wdata;
    end
    e.port = port; e.err = expErr; e.rdata = expRdata;
    sbQ.push_back(e);
    lat = 0; seen = 1'b0; memTouched = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_we !== SZ_NONE || mem_re !== 1'b0) memTouched = 1'b1;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        seen = 1'b1;
        e = sbQ.pop_front();
        checks++;
        if ({ack1, ack0} !== (e.port ? 2'b10 : 2'b01)) begin
          errors++;
          $display("[TB] FAIL %s ack: got %b want %b", name, {ack1, ack0}, (e.port ? 2'b10 : 2'b01));
        end
        checks++;
        if ({err1, err0} !== (e.err ? (e.port ? 2'b10 : 2'b01) : 2'b00)) begin
          errors++;
          $display("[TB] FAIL %s err: got %b want err=%b on port %0d", name, {err1, err0}, e.err, e.port);
        end
        checks++;
        if (rdata !== e.rdata) begin
          errors++;
          $display("[TB] FAIL %s rdata: got %h want %h", name, rdata, e.rdata);
        end
      end
    end
    clearInputs();
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s timeout: no ack within %0d cycles", name, lat);
      sbQ.delete();
    end else if (lat != expLat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, expLat);
    end
    if (expErr) begin
      checks++;
      if (memTouched) begin
        errors++;
        $display("[TB] FAIL %s memstrobe: got memory cycle want none", name);
      end
    end
  endtask

  // Reset with port 0 already requesting: nothing may happen until release,
  // then the held read is served and acked in the third cycle.
  task automatic test_reset();
    exp_t e;
    int   lat;
    logic seen;
    rst = 1'b0; memClear = 1'b1;
    clearInputs();
    req0 = 1'b1; re0 = 1'b1; addr0 = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_busy: got %b want 0", busy);
      end
      checks++;
      if (mem_we !== SZ_NONE || mem_re !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_memstrobe: got we=%b re=%b want 000/0", mem_we, mem_re);
      end
    end
    checks++;
    if ({ack1, ack0, err1, err0} !== 4'b0000 || rdata !== '0 || mem_addr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ack=%b err=%b rdata=%h addr=%h want zeros",
               {ack1, ack0}, {err1, err0}, rdata, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1; memClear = 1'b0;
    e.port = PORT_FETCH; e.err = 1'b0; e.rdata = '0;
    sbQ.push_back(e);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        seen = 1'b1;
        e = sbQ.pop_front();
        checks++;
        if ({ack1, ack0, err0} !== 3'b010 || rdata !== e.rdata) begin
          errors++;
          $display("[TB] FAIL reset_first_ack: got ack=%b err0=%b rdata=%h want 01/0/%h",
                   {ack1, ack0}, err0, rdata, e.rdata);
        end
      end
    end
    clearInputs();
    checks++;
    if (!seen || lat != 3) begin
      errors++;
      $display("[TB] FAIL reset_latency: got seen=%b cycles=%0d want 3", seen, lat);
      sbQ.delete();
    end
  endtask

  task automatic test_write_read();
    doTransaction("wr_word", PORT_LSU, 1'b0, SZ_W, 32'd4, 32'hDEADBEEF, 1'b0, 32'h0, 3);
    doTransaction("rd_word", PORT_FETCH, 1'b1, SZ_NONE, 32'd4, 32'h0, 1'b0, 32'hDEADBEEF, 3);
    doTransaction("wr_byte", PORT_LSU, 1'b0, SZ_B, 32'd17, 32'h000000C3, 1'b0, 32'h0, 3);
    doTransaction("rd_byte_word", PORT_LSU, 1'b1, SZ_NONE, 32'd16, 32'h0, 1'b0, 32'h0000C300, 3);
  endtask

  task automatic test_boundary();
    doTransaction("wr_half_top", PORT_LSU, 1'b0, SZ_H, 32'd30, 32'h0000A55A, 1'b0, 32'h0, 3);
    doTransaction("rd_top_word", PORT_LSU, 1'b1, SZ_NONE, 32'd28, 32'h0, 1'b0, 32'hA55A0000, 3);
    doTransaction("rd_past_top", PORT_FETCH, 1'b1, SZ_NONE, 32'd29, 32'h0, 1'b1, 32'h0, 2);
    doTransaction("wr_wrap_addr", PORT_LSU, 1'b0, SZ_B, 32'hFFFFFFFF, 32'h11, 1'b1, 32'h0, 2);
  endtask

  task automatic test_illegal();
    doTransaction("wr_word_oob", PORT_LSU, 1'b0, SZ_W, 32'd30, 32'h01020304, 1'b1, 32'h0, 2);
    doTransaction("bad_size", PORT_LSU, 1'b0, 3'b101, 32'd0, 32'h01020304, 1'b1, 32'h0, 2);
    doTransaction("byte_with_re", PORT_LSU, 1'b1, SZ_B, 32'd0, 32'h01020304, 1'b1, 32'h0, 2);
    doTransaction("no_operation", PORT_LSU, 1'b0, SZ_NONE, 32'd0, 32'h0, 1'b1, 32'h0, 2);
  endtask

  // Both ports held from reset release: grants alternate 0,1,0,1 and each
  // ack follows the previous one by three cycles.
  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    int   acks;
    int   lastCyc;
    rst = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    req0 = 1'b1; re0 = 1'b1; addr0 = 32'd4;
    req1 = 1'b1; we1 = SZ_W; addr1 = 32'd12; wdata1 = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      e.port = (i % 2 == 1); e.err = 1'b0;
      e.rdata = (i % 2 == 1) ? 32'h0 : 32'hDEADBEEF;
      sbQ.push_back(e);
    end
    cyc = 0; acks = 0; lastCyc = 0;
    while (acks < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        e = sbQ.pop_front();
        checks++;
        if ({ack1, ack0} !== (e.port ? 2'b10 : 2'b01) || {err1, err0} !== 2'b00 || rdata !== e.rdata) begin
          errors++;
          $display("[TB] FAIL b2b_grant%0d: got ack=%b err=%b rdata=%h want port %0d rdata=%h",
                   acks, {ack1, ack0}, {err1, err0}, rdata, e.port, e.rdata);
        end
        checks++;
        if (cyc != lastCyc + 3) begin
          errors++;
          $display("[TB] FAIL b2b_spacing%0d: got cycle %0d want %0d", acks, cyc, lastCyc + 3);
        end
        lastCyc = cyc;
        acks++;
        if (acks == 4) clearInputs();
      end
    end
    checks++;
    if (acks != 4) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d acks want 4", acks);
      clearInputs();
    end
    sbQ.delete();
  endtask

  // Reset during the ACCESS cycle of a write: the strobe must drop at once,
  // no ack may follow, and the location must still read back as zero.
  task automatic test_reset_mid();
    logic ackSeen;
    @(posedge clk); #1;
    req1 = 1'b1; we1 = SZ_W; addr1 = 32'd8; wdata1 = 32'hCAFEF00D;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || mem_we !== SZ_W || mem_addr !== 32'd8) begin
      errors++;
      $display("[TB] FAIL abort_inflight: got busy=%b we=%b addr=%h want 1/111/8", busy, mem_we, mem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_we !== SZ_NONE || mem_re !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_strobe: got we=%b re=%b want 000/0", mem_we, mem_re);
    end
    ackSeen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) ackSeen = 1'b1;
      if (i == 0) clearInputs();
    end
    checks++;
    if (ackSeen) begin
      errors++;
      $display("[TB] FAIL abort_ack: got an ack want none");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    doTransaction("rd_after_abort", PORT_FETCH, 1'b1, SZ_NONE, 32'd8, 32'h0, 1'b0, 32'h0, 3);
  endtask

  initial begin
    rst = 1'b0;
    memClear = 1'b1;
    clearInputs();
    test_reset();
    test_write_read();
    test_boundary();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
